// File: rtl/shift_pkg.sv
// Shared types and the round-robin pick function for the shift request scheduler.
package shift_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ASL = 2'b11
  } shift_dir_e;

  localparam int MAX_REQ = 8;

  // First asserted valid at or after ptr, searching upward and wrapping modulo num_req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 num_req = MAX_REQ);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % num_req;
      if (k < num_req && !found && valid[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational log shifter: one stage per amount bit, zero or sign fill, no rotate.
module barrel_shift_core
  import shift_pkg::*;
#(
  parameter  int NUM_STAGE = 3,
  localparam int W         = 2**NUM_STAGE
) (
  input  logic [W-1:0]         data,
  input  logic [NUM_STAGE-1:0] amt,
  input  shift_dir_e           dir,
  output logic [W-1:0]         result
);

  logic [NUM_STAGE:0][W-1:0] stage;
  logic                      shift_right;
  logic                      fill;

  assign shift_right = (dir == LSR) || (dir == ASR);
  assign fill        = (dir == ASR) & data[W-1];
  assign stage[0]    = data;

  for (genvar gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
    localparam int SH = 2**gi;
    logic [W-1:0] shifted;

    always_comb begin
      if (shift_right) begin
        shifted = {{SH{fill}}, stage[gi][W-1:SH]};
      end else begin
        shifted = {stage[gi][W-1-SH:0], {SH{1'b0}}};
      end
    end

    assign stage[gi+1] = amt[gi] ? shifted : stage[gi];
  end

  assign result = stage[NUM_STAGE];

endmodule

// File: rtl/shift_req_scheduler.sv
// Round-robin arbiter sharing one barrel shifter between NUM_REQ requesters,
// with a single registered result stage behind a valid/ready handshake.
module shift_req_scheduler
  import shift_pkg::*;
#(
  parameter  int NUM_STAGE = 3,
  parameter  int NUM_REQ   = 4,
  localparam int W         = 2**NUM_STAGE,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][W-1:0]         req_data,
  input  logic [NUM_REQ-1:0][NUM_STAGE-1:0] req_amt,
  input  logic [NUM_REQ-1:0][1:0]           req_dir,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [W-1:0]                      out_data,
  output logic [IDW-1:0]                    out_id,
  output logic                              busy
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic           state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           can_accept;
  logic           grant;
  logic [IDW-1:0] grant_idx;
  logic [W-1:0]   sel_data;
  logic [NUM_STAGE-1:0] sel_amt;
  logic [1:0]     sel_dir;
  logic [W-1:0]   shift_result;

  assign can_accept = (state_q == ST_EMPTY) || out_ready;
  assign grant_idx  = IDW'(rr_pick(MAX_REQ'(req_valid), 3'(ptr_q), NUM_REQ));
  // rst_n gating keeps every ready low while reset is held.
  assign grant      = can_accept && (|req_valid) && rst_n;
  assign req_ready  = grant ? (NUM_REQ'(1) << grant_idx) : '0;

  assign sel_data = req_data[grant_idx];
  assign sel_amt  = req_amt[grant_idx];
  assign sel_dir  = req_dir[grant_idx];

  barrel_shift_core #(
    .NUM_STAGE (NUM_STAGE)
  ) u_core (
    .data   (sel_data),
    .amt    (sel_amt),
    .dir    (shift_dir_e'(sel_dir)),
    .result (shift_result)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (grant) begin
      data_d = shift_result;
      id_d   = grant_idx;
      ptr_d  = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : IDW'(int'(grant_idx) + 1);
    end
    case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !grant) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign busy      = out_valid && !out_ready;

endmodule

// File: tb/tb_shift_req_scheduler.sv
// Randomised and directed bench for shift_req_scheduler against a behavioural model.
module tb_shift_req_scheduler;

  localparam int NS  = 3;
  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0]            req_ready;
  logic [NR-1:0][W-1:0]     req_data;
  logic [NR-1:0][NS-1:0]    req_amt;
  logic [NR-1:0][1:0]       req_dir;
  logic                     out_valid;
  logic                     out_ready;
  logic [W-1:0]             out_data;
  logic [IDW-1:0]           out_id;
  logic                     busy;

  int checks   = 0;
  int failures = 0;

  bit         m_valid;
  logic [7:0] m_data;
  int         m_id;
  int         m_ptr;

  shift_req_scheduler #(.NUM_STAGE(NS), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_dir   (req_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input logic [1:0] dir);
    case (dir)
      2'b01:   return d >> a;
      2'b10:   return 8'($signed(d) >>> a);
      default: return 8'(d << a);
    endcase
  endfunction

  function automatic int ref_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_valid && !out_ready) return -1;
    return ref_pick(req_valid, m_ptr);
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  // Advance the model by one edge, then sample the DUT 1 time unit after it.
  task automatic tick();
    int g;
    g = exp_grant();
    if (g >= 0) begin
      m_data  = ref_shift(req_data[g], int'(req_amt[g]), req_dir[g]);
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % NR;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    req_data  = '0;
    req_amt   = '0;
    req_dir   = '0;
    out_ready = 1'b0;
    model_reset();
    #12;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    if (out_id !== 2'd0) begin failures++; $display("FAIL reset_out_id got=%0d want=0", out_id); end
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    $display("reset: out_valid=%b req_ready=%b", out_valid, req_ready);
    req_valid = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_valid   = 4'b0100;
    req_data[2] = 8'hB4;
    req_amt[2]  = 3'd2;
    req_dir[2]  = 2'b01;
    out_ready   = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b want=0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b want=1", out_valid); end
    if (out_data !== 8'h2D) begin failures++; $display("FAIL single_data got=%h want=2d", out_data); end
    if (out_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d want=2", out_id); end
    $display("single: id=%0d data=%h", out_id, out_data);
    tick();
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b want=0", out_valid); end
    if (out_data !== 8'h2D) begin failures++; $display("FAIL drain_hold got=%h want=2d", out_data); end
  endtask

  task automatic test_directions();
    logic [7:0] want [5];
    logic [1:0] dirs [5];
    logic [2:0] amts [5];
    want = '{8'hB0, 8'h12, 8'hF2, 8'hB0, 8'h96};
    dirs = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    amts = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid   = 4'b0001;
      req_data[0] = 8'h96;
      req_amt[0]  = amts[i];
      req_dir[0]  = dirs[i];
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL dir_ready[%0d] got=%b want=0001", i, req_ready); end
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL dir_valid[%0d] got=%b want=1", i, out_valid); end
      if (out_data !== want[i]) begin failures++; $display("FAIL dir_data[%0d] got=%h want=%h", i, out_data, want[i]); end
      if (out_id !== 2'd0) begin failures++; $display("FAIL dir_id[%0d] got=%0d want=0", i, out_id); end
      $display("dir=%b amt=%0d data=%h", dirs[i], amts[i], out_data);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0] want;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 4'hF;
      for (int r = 0; r < NR; r++) begin
        req_data[r] = 8'($urandom);
        req_amt[r]  = 3'($urandom);
        req_dir[r]  = 2'($urandom);
      end
      want = ref_shift(req_data[i % NR], int'(req_amt[i % NR]), req_dir[i % NR]);
      #1;
      checks++;
      if (req_ready !== 4'(1 << (i % NR))) begin failures++; $display("FAIL rr_ready[%0d] got=%b", i, req_ready); end
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d] got=%b want=1", i, out_valid); end
      if (out_id !== 2'(i % NR)) begin failures++; $display("FAIL rr_id[%0d] got=%0d want=%0d", i, out_id, i % NR); end
      if (out_data !== want) begin failures++; $display("FAIL rr_data[%0d] got=%h want=%h", i, out_data, want); end
      $display("rr: id=%0d data=%h", out_id, out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] want;
    req_valid   = 4'b0100;
    req_data[2] = 8'hB4;
    req_amt[2]  = 3'd2;
    req_dir[2]  = 2'b01;
    out_ready   = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_load_ready got=%b want=0100", req_ready); end
    tick();
    out_ready = 1'b0;
    req_valid = 4'hF;
    for (int r = 0; r < NR; r++) req_data[r] = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 2;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b want=0000", i, req_ready); end
      if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy[%0d] got=%b want=1", i, busy); end
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b want=1", i, out_valid); end
      if (out_data !== 8'h2D) begin failures++; $display("FAIL bp_data[%0d] got=%h want=2d", i, out_data); end
      if (out_id !== 2'd2) begin failures++; $display("FAIL bp_id[%0d] got=%0d want=2", i, out_id); end
      $display("stall %0d: data=%h busy=%b", i, out_data, busy);
    end
    out_ready = 1'b1;
    want = ref_shift(req_data[3], int'(req_amt[3]), req_dir[3]);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%b want=1000", req_ready); end
    tick();
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_b2b_valid got=%b want=1", out_valid); end
    if (out_id !== 2'd3) begin failures++; $display("FAIL bp_b2b_id got=%0d want=3", out_id); end
    if (out_data !== want) begin failures++; $display("FAIL bp_b2b_data got=%h want=%h", out_data, want); end
    $display("release: id=%0d data=%h", out_id, out_data);
  endtask

  task automatic test_wrap_skip();
    out_ready = 1'b1;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL wrap_ready got=%b want=0010", req_ready); end
    tick();
    checks++;
    if (out_id !== 2'd1) begin failures++; $display("FAIL wrap_id got=%0d want=1", out_id); end
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL wrap_ptr got=%b want=0100", req_ready); end
    $display("wrap: id=%0d next_ready=%b", out_id, req_ready);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NR; r++) begin
        req_data[r] = 8'($urandom);
        req_amt[r]  = 3'($urandom);
        req_dir[r]  = 2'($urandom);
      end
      #1;
      checks += 2;
      if (req_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, req_ready, exp_ready()); end
      if (busy !== (m_valid && !out_ready)) begin failures++; $display("FAIL rnd_busy[%0d] got=%b", i, busy); end
      tick();
      checks += 3;
      if (out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, out_valid, m_valid); end
      if (out_data !== m_data) begin failures++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, out_data, m_data); end
      if (out_id !== 2'(m_id)) begin failures++; $display("FAIL rnd_id[%0d] got=%0d want=%0d", i, out_id, m_id); end
      $display("rnd %0d: valid=%b id=%0d data=%h", i, out_valid, out_id, out_data);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0001;
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b want=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
    if (out_data !== 8'h00) begin failures++; $display("FAIL mid_async_data got=%h want=00", out_data); end
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_async_ready got=%b want=0000", req_ready); end
    @(posedge clk);
    #1;
    req_valid = 4'b1001;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_ready got=%b want=0001", req_ready); end
    tick();
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_first_valid got=%b want=1", out_valid); end
    if (out_id !== 2'd0) begin failures++; $display("FAIL mid_first_id got=%0d want=0", out_id); end
    $display("reset_mid: first id=%0d", out_id);
  endtask

  initial begin
    test_reset();
    test_single();
    test_directions();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_req_scheduler.md
Name: shift_req_scheduler

Overview:
- Shares one combinational barrel-shift datapath between NUM_REQ requesters.
- Each requester presents an operand, a shift amount and a direction over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The shift result is registered and returned with the requester ID over an output valid/ready handshake.
- Sits between the ALU issue logic and the writeback mux.

Parameters:
- NUM_STAGE, 3, shifter stage count; data width W = 2**NUM_STAGE; max shift W-1.
- NUM_REQ, 4, number of requesters (2..8).
- IDW, $clog2(NUM_REQ), requester ID width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  NUM_REQ x W  operand per requester.
- req_amt  in  NUM_REQ x NUM_STAGE  shift amount per requester; bit i enables the 2**i stage.
- req_dir  in  NUM_REQ x 2  shift direction per requester.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  shifted result.
- out_id  out  IDW  index of the requester that produced out_data.
- busy  out  1  high while out_valid=1 and out_ready=0 (stall indicator).

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - out_valid=0, out_data=0, out_id=0;
  - req_ready=0 (all bits), busy=0;
  - round-robin pointer rr_ptr=0.
- Directions:
  - 00 logical left, zero fill.
  - 01 logical right, zero fill.
  - 10 arithmetic right, MSB (sign) fill.
  - 11 arithmetic left, identical to 00.
- Shift is applied in stages, as the log shifter does. amt=0 passes data unchanged. Bits shifted out are discarded (no rotate).
- Accept condition: can_accept = !out_valid || out_ready.
- Grant:
  - When can_accept=1 and any req_valid=1, exactly one req_ready bit is asserted, combinationally.
  - The granted index is the first asserted req_valid at or after rr_ptr, searching upward with wrap-around modulo NUM_REQ.
  - req_ready is 0 for every bit when can_accept=0 or no request is valid.
  - req_ready depends only on req_valid, rr_ptr and out_valid/out_ready, so a requester may lower req_valid the cycle after its handshake.
- Handshake req_valid[g] & req_ready[g] at edge N:
  - out_data <= shift(req_data[g], req_amt[g], req_dir[g]);
  - out_id <= g; out_valid <= 1;
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: one cycle, request handshake to out_valid.
- Throughput: one result per cycle when out_ready is held high.
- Output handshake with no new grant at the same edge: out_valid <= 0. out_data and out_id hold their last values.
- Simultaneous output drain and new grant at one edge: the new result is loaded and out_valid stays 1 (back-to-back, no bubble).
- Stall (out_valid=1, out_ready=0):
  - out_data and out_id are held stable.
  - All req_ready=0; rr_ptr is held; busy=1.
- No grant in a cycle: rr_ptr is unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Reset asserted mid-transfer: the in-flight result is dropped and state is cleared immediately. After release, the first grant goes to requester 0 if it is valid.
- State machine, 2 states, derived from out_valid:
  - EMPTY -> FULL on grant.
  - FULL -> FULL on (out_ready & grant) or !out_ready.
  - FULL -> EMPTY on out_ready & !grant.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic [1:0] shift_dir_e {LSL=2'b00, LSR=2'b01, ASR=2'b10, ASL=2'b11};
  - function rr_pick(valid, ptr), returning the granted index.
- Sub-module barrel_shift_core #(NUM_STAGE), purely combinational: inputs data, amt, dir; output result.
- The scheduler instantiates one barrel_shift_core, fed by the granted requester's fields through a NUM_REQ:1 mux.

Test Plan:
- Single request: NUM_STAGE=3; req 2 sends data=8'hB4, amt=3'd2, dir=LSR; out_ready=1 -> next cycle out_valid=1, out_data=8'h2D, out_id=2; rr_ptr=3.
- Direction coverage: data=8'h96, amt=3'd3 -> LSL 8'hB0, LSR 8'h12, ASR 8'hF2, ASL 8'hB0; amt=0 returns 8'h96.
- Round-robin: all 4 requesters valid continuously, out_ready=1 -> out_id sequence 0,1,2,3,0,1, one result per cycle, no bubbles.
- Backpressure: out_ready=0 for 3 cycles with result 8'h2D valid -> out_data stable and busy=1, req_ready=0 throughout. Raising out_ready drains 8'h2D and loads the next granted result at the same edge.
- Wrap and skip: rr_ptr=3, only req 1 valid -> req 1 granted, rr_ptr becomes 2.
- Reset mid-operation: drop rst_n while out_valid=1 and out_ready=0 -> out_valid=0 immediately (asynchronously). After release, with reqs 0 and 3 valid, req 0 is granted first.
